// File: rtl/spi_packet_master_if.sv
// rtl/spi_packet_master_if.sv - request/response bundle for spi_packet_master
//
// Purpose: groups the bridge-side request/response handshake of the SPI
// packet master.
// Ports:
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_wr               1 = write, 0 = read
//   req_addr[7:0]        target address
//   req_wdata[31:0]      write data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata[31:0]      read data, held between reads
//   busy                 transaction in flight
// Modports: master = bridge side, slave = spi_packet_master side.
interface spi_packet_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_packet_master.sv
// rtl/spi_packet_master.sv - SPI mode-0 master issuing 41-bit packets
//
// Purpose: accepts one write/read request, shifts {wr, addr, data} MSB-first
// on mosi and, for reads, clocks a 32-bit word back from miso.
// Parameters:
//   CLK_DIV     SCLK cycles per spi_clk half-period (2..255)
//   TURNAROUND  idle SCLK cycles between read command and read data (>=1)
// Ports:
//   SCLK, SRESET   system clock, asynchronous active-high reset
//   bus            request/response bundle (slave modport)
//   spi_clk, cs    SPI clock (idle low) and active-low chip select
//   mosi, miso     serial data out / in
module spi_packet_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned TURNAROUND = 8
) (
  input  logic               SCLK,
  input  logic               SRESET,
  spi_packet_master_if.slave bus,
  output logic               spi_clk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT_TX, S_TURN, S_SHIFT_RX, S_CS_HOLD, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bit_q, bit_d;
  logic [40:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_q, wr_d;
  logic             spi_clk_q, spi_clk_d;
  logic             cs_q, cs_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             half_done;

  assign half_done = (cnt_q == DIV_LAST);

  always_ff @(posedge SCLK or posedge SRESET) begin
    if (SRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      wr_q        <= 1'b0;
      spi_clk_q   <= 1'b0;
      cs_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      wr_q        <= wr_d;
      spi_clk_q   <= spi_clk_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    wr_d        = wr_q;
    spi_clk_d   = spi_clk_q;
    cs_d        = cs_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          state_d = S_CS_SETUP;
          wr_d    = bus.req_wr;
          tx_d    = {bus.req_wr, bus.req_addr, bus.req_wr ? bus.req_wdata : 32'h0};
          cs_d    = 1'b0;
        end
      end
      S_CS_SETUP: begin
        if (half_done) begin
          state_d   = S_SHIFT_TX;
          cnt_d     = '0;
          bit_d     = '0;
          spi_clk_d = 1'b1;
        end
      end
      S_SHIFT_TX: begin
        if (half_done) begin
          cnt_d = '0;
          if (spi_clk_q) begin
            // Falling edge: next bit onto mosi. After 41 shifts the register
            // is all zero, which keeps mosi low for the rest of the transfer.
            spi_clk_d = 1'b0;
            tx_d      = {tx_q[39:0], 1'b0};
            bit_d     = bit_q + 6'd1;
          end else if (bit_q == 6'd41) begin
            // The low half after the last fall is spent before leaving.
            state_d = wr_q ? S_CS_HOLD : S_TURN;
          end else begin
            spi_clk_d = 1'b1;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d   = S_SHIFT_RX;
          cnt_d     = '0;
          bit_d     = '0;
          spi_clk_d = 1'b1;
          rx_d      = {rx_q[30:0], miso};
        end
      end
      S_SHIFT_RX: begin
        if (half_done) begin
          cnt_d = '0;
          if (spi_clk_q) begin
            spi_clk_d = 1'b0;
            bit_d     = bit_q + 6'd1;
          end else if (bit_q == 6'd32) begin
            state_d = S_CS_HOLD;
          end else begin
            // miso is sampled on the same SCLK edge that raises spi_clk.
            spi_clk_d = 1'b1;
            rx_d      = {rx_q[30:0], miso};
          end
        end
      end
      S_CS_HOLD: begin
        if (half_done) begin
          state_d     = S_DONE;
          cs_d        = 1'b1;
          rsp_valid_d = 1'b1;
          if (!wr_q) rdata_d = rx_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign spi_clk       = spi_clk_q;
  assign cs            = cs_q;
  assign mosi          = tx_q[40];

endmodule

// File: tb/tb_spi_packet_master.sv
// tb/tb_spi_packet_master.sv - self-checking bench for spi_packet_master
module tb_spi_packet_master;
  localparam int CLKP = 10;

  logic SCLK = 1'b0;
  logic SRESET = 1'b1;
  always #(CLKP/2) SCLK = ~SCLK;

  int cyc = 0;
  always @(posedge SCLK) cyc <= cyc + 1;

  spi_packet_master_if b0();
  spi_packet_master_if b1();
  logic spi_clk0, cs0, mosi0, miso0;
  logic spi_clk1, cs1, mosi1, miso1;

  spi_packet_master #(.CLK_DIV(4), .TURNAROUND(8)) u0 (
    .SCLK(SCLK), .SRESET(SRESET), .bus(b0),
    .spi_clk(spi_clk0), .cs(cs0), .mosi(mosi0), .miso(miso0)
  );
  spi_packet_master #(.CLK_DIV(2), .TURNAROUND(1)) u1 (
    .SCLK(SCLK), .SRESET(SRESET), .bus(b1),
    .spi_clk(spi_clk1), .cs(cs1), .mosi(mosi1), .miso(miso1)
  );

  int n_checks = 0;
  int n_fail = 0;

  // SPI slave models: collect the command bits seen at rising edges and
  // drive the response word MSB-first on falling edges after the command.
  int          rises0 = 0, rises1 = 0, per_bad0 = 0, per_bad1 = 0;
  logic [40:0] cap0 = '0, cap1 = '0;
  time         last0 = 0, last1 = 0;
  logic [31:0] rx_word0 = '0, rx_word1 = '0;
  logic [31:0] exp_rdata [2];

  initial begin
    miso0 = 1'b0;
    miso1 = 1'b0;
  end

  always @(posedge spi_clk0 or negedge cs0) begin
    if (!spi_clk0) begin
      rises0 = 0;
      cap0 = '0;
    end else begin
      if (rises0 < 41) cap0 = {cap0[39:0], mosi0};
      if (rises0 != 0 && rises0 != 41 && ($time - last0) != 8*CLKP) per_bad0++;
      last0 = $time;
      rises0++;
    end
  end
  always @(negedge spi_clk0)
    miso0 = (rises0 >= 41 && rises0 < 73) ? rx_word0[72 - rises0] : 1'b0;

  always @(posedge spi_clk1 or negedge cs1) begin
    if (!spi_clk1) begin
      rises1 = 0;
      cap1 = '0;
    end else begin
      if (rises1 < 41) cap1 = {cap1[39:0], mosi1};
      if (rises1 != 0 && rises1 != 41 && ($time - last1) != 4*CLKP) per_bad1++;
      last1 = $time;
      rises1++;
    end
  end
  always @(negedge spi_clk1)
    miso1 = (rises1 >= 41 && rises1 < 73) ? rx_word1[72 - rises1] : 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic w,
                       input logic [7:0] a, input logic [31:0] d);
    if (i != 0) begin
      b1.req_valid = v; b1.req_wr = w; b1.req_addr = a; b1.req_wdata = d;
    end else begin
      b0.req_valid = v; b0.req_wr = w; b0.req_addr = a; b0.req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int i);
    return (i != 0) ? b1.req_ready : b0.req_ready;
  endfunction
  function automatic logic bsy(input int i);
    return (i != 0) ? b1.busy : b0.busy;
  endfunction
  function automatic logic rsp(input int i);
    return (i != 0) ? b1.rsp_valid : b0.rsp_valid;
  endfunction

  // Starts at a negedge, returns at the negedge of the rsp_valid cycle.
  task automatic run_txn(input int i, input logic w, input logic [7:0] a,
                         input logic [31:0] wd, input logic [31:0] rw,
                         input bit mutate, input string tag,
                         output int t_acc, output int t_rsp);
    int d, ta, ready_bad, exp_cyc, nrise;
    logic [40:0] pkt;
    d = (i != 0) ? 2 : 4;
    ta = (i != 0) ? 1 : 8;
    pkt = {w, a, w ? wd : 32'h0};
    exp_cyc = 1 + 84*d + (w ? 0 : ta + 64*d);
    if (i != 0) rx_word1 = rw; else rx_word0 = rw;
    drive(i, 1'b1, w, a, wd);
    t_acc = -1;
    for (int k = 0; k < 20; k++) begin
      if (rdy(i)) begin
        t_acc = cyc;
        break;
      end
      @(negedge SCLK);
    end
    check({tag, ".accepted"}, 64'(t_acc >= 0), 64'd1);
    check({tag, ".cs_idle"}, 64'((i != 0) ? cs1 : cs0), 64'd1);
    @(negedge SCLK);
    drive(i, 1'b0, w, a, wd);
    ready_bad = 0;
    t_rsp = -1;
    for (int k = 0; k < 2000; k++) begin
      if (rsp(i)) begin
        t_rsp = cyc;
        break;
      end
      if (rdy(i) !== 1'b0 || bsy(i) !== 1'b1) ready_bad++;
      if (mutate) drive(i, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
      @(negedge SCLK);
    end
    drive(i, 1'b0, w, a, wd);
    nrise = (i != 0) ? rises1 : rises0;
    if (!w) exp_rdata[i] = rw;
    check({tag, ".rsp_cycle"}, 64'(t_rsp - t_acc), 64'(exp_cyc));
    check({tag, ".rise_count"}, 64'(nrise), w ? 64'd41 : 64'd73);
    check({tag, ".packet"}, 64'((i != 0) ? cap1 : cap0), 64'(pkt));
    check({tag, ".rdata"}, 64'((i != 0) ? b1.rsp_rdata : b0.rsp_rdata), 64'(exp_rdata[i]));
    check({tag, ".busy_window"}, 64'(ready_bad), 64'd0);
    check({tag, ".rsp_flags"}, {61'd0, rdy(i), bsy(i), ((i != 0) ? cs1 : cs0)}, 64'b011);
  endtask

  initial begin
    int ta1, tr1, ta2, tr2, k, rsp_seen;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 32'h0);

    @(negedge SCLK);
    check("reset.cs", 64'(cs0), 64'd1);
    check("reset.spi_clk", 64'(spi_clk0), 64'd0);
    check("reset.mosi", 64'(mosi0), 64'd0);
    check("reset.ready_busy_rsp", {61'd0, b0.req_ready, b0.busy, b0.rsp_valid}, 64'b100);
    check("reset.rdata", 64'(b0.rsp_rdata), 64'd0);
    repeat (2) @(negedge SCLK);
    SRESET = 1'b0;
    @(negedge SCLK);

    // Write, then a read queued straight behind it.
    run_txn(0, 1'b1, 8'hA5, 32'hDEADBEEF, 32'h0, 1'b0, "wr_a5", ta1, tr1);
    run_txn(0, 1'b0, 8'h3C, 32'hCAFEF00D, 32'h12345678, 1'b0, "rd_3c", ta2, tr2);
    check("b2b.accept_after_done", 64'(ta2), 64'(tr1 + 1));

    // Random transactions with request fields churning after acceptance.
    for (int n = 0; n < 4; n++) begin
      repeat (2) @(negedge SCLK);
      run_txn(0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, 1'b1,
              $sformatf("rand%0d", n), ta1, tr1);
    end

    // Reset in the middle of the command phase.
    repeat (2) @(negedge SCLK);
    drive(0, 1'b1, 1'b1, 8'h77, 32'h01234567);
    @(negedge SCLK);
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0);
    k = 0;
    while (rises0 < 20 && k < 2000) begin
      @(negedge SCLK);
      k++;
    end
    check("rst.reached_bit20", 64'(rises0 == 20), 64'd1);
    SRESET = 1'b1;
    #1;
    check("rst.pins", {61'd0, cs0, spi_clk0, mosi0}, 64'b100);
    check("rst.ready_busy", {62'd0, b0.req_ready, b0.busy}, 64'b10);
    check("rst.rdata", 64'(b0.rsp_rdata), 64'd0);
    @(negedge SCLK);
    SRESET = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    rsp_seen = 0;
    repeat (400) begin
      @(negedge SCLK);
      if (b0.rsp_valid) rsp_seen++;
    end
    check("rst.no_rsp", 64'(rsp_seen), 64'd0);
    run_txn(0, 1'b1, 8'h5A, 32'h0F0F1234, 32'h0, 1'b0, "wr_after_rst", ta1, tr1);

    // Fastest divider, minimum turnaround.
    repeat (2) @(negedge SCLK);
    run_txn(1, 1'b0, 8'h11, 32'h0, 32'hFFFFFFFF, 1'b0, "div2_ones", ta1, tr1);
    repeat (2) @(negedge SCLK);
    run_txn(1, 1'b0, 8'h22, 32'h0, 32'h00000001, 1'b0, "div2_one", ta1, tr1);

    check("period.div4", 64'(per_bad0), 64'd0);
    check("period.div2", 64'(per_bad1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_packet_master.md
# spi_packet_master

SPI master controller that issues the team's 41-bit SPI packets to the on-chip SPI slave memory. Accepts a single write or read request on a valid/ready port from the bridge side, serialises {wr, addr[7:0], data[31:0]} MSB-first on MOSI, and for reads clocks back the 32-bit response on MISO. Runs entirely on SCLK and generates spi_clk (mode 0: idle low, drive on falling edge, sample on rising edge).

## Interface

- CLK_DIV, 4, SCLK cycles per spi_clk half-period; legal range 2..255
- TURNAROUND, 8, SCLK cycles with cs low and spi_clk low between read-command and read-data phases; ≥1

- SCLK  input  1  system clock, all logic on posedge
- SRESET  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; transfer accepted when req_valid && req_ready
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  8  target address
- req_wdata  input  32  write data (ignored for reads; sent as 0)
- rsp_valid  output  1  one-cycle pulse on completion of any transaction
- rsp_rdata  output  32  read data; updated only on read completion, held otherwise
- busy  output  1  high from acceptance through the rsp_valid cycle
- spi_clk  output  1  SPI clock
- cs  output  1  chip select, active low
- mosi  output  1  master out
- miso  input  1  master in

## Operation

- Acceptance captures req_wr/req_addr/req_wdata into a 41-bit shift register {req_wr, req_addr, wr ? req_wdata : 0}; later input changes ignored.
- States: IDLE -> CS_SETUP -> SHIFT_TX -> (write) CS_HOLD / (read) TURN -> SHIFT_RX -> CS_HOLD -> DONE -> IDLE.
- IDLE: cs=1, spi_clk=0, mosi=0, req_ready=1, busy=0.
- CS_SETUP: cs=0, mosi=packet bit 40, spi_clk low for CLK_DIV cycles.
- SHIFT_TX: 41 spi_clk periods; half-period counter toggles spi_clk at count CLK_DIV-1; on each falling edge mosi advances to next bit; 6-bit counter tracks bits; exit after the 41st falling edge.
- TURN: mosi=0, spi_clk=0, cs=0 for TURNAROUND cycles.
- SHIFT_RX: 32 spi_clk periods; miso sampled into rx shift register (MSB first) in the SCLK cycle spi_clk rises; exit after 32nd falling edge.
- CS_HOLD: spi_clk=0, mosi=0, cs=0 for CLK_DIV cycles; cs rises on exit.
- DONE: cs=1, rsp_valid=1 for one cycle; on reads rsp_rdata loads rx register same cycle.
- New request not accepted in DONE; earliest next acceptance is the cycle after DONE.
- SRESET mid-transaction: all state/outputs forced to reset values immediately; no rsp_valid for aborted transfer.
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, spi_clk=0, cs=1, mosi=0.

## Timing

- Acceptance at cycle T; cs falls at T+1 (all SPI outputs registered).
- First spi_clk rise at T+1+CLK_DIV; spi_clk period 2*CLK_DIV cycles, 50% duty.
- Write: rsp_valid at T+1+84*CLK_DIV (CS_SETUP CLK_DIV + 82*CLK_DIV + CS_HOLD CLK_DIV); cs rises in that cycle.
- Read: rsp_valid at T+1+84*CLK_DIV+TURNAROUND+64*CLK_DIV.
- mosi stable a full half-period before and after each rising spi_clk edge.
- spi_clk never glitches; no edge outside SHIFT_TX/SHIFT_RX.

## Test plan

- Write addr 0xA5 data 0xDEADBEEF, CLK_DIV=4 -> exactly 41 rising edges, mosi bits at rises = 1,0xA5,0xDEADBEEF MSB first; rsp_valid at T+337; rsp_rdata unchanged (0).
- Read addr 0x3C, miso model drives 0x12345678 MSB first on falling edges -> command bits 0,0x3C,0x00000000; 32 rising edges after TURNAROUND; rsp_rdata=0x12345678 with rsp_valid at T+1+336+8+256.
- Back-to-back: req_valid held with write then read queued -> req_ready=0 from T until the cycle after DONE; second accepted exactly one cycle after rsp_valid; cs high ≥1 cycle between.
- Input mutation: change req_addr/req_wdata every cycle after acceptance -> transmitted packet equals captured values.
- SRESET asserted at bit 20 of SHIFT_TX -> same-cycle cs=1, spi_clk=0, mosi=0, busy=0, req_ready=1; no rsp_valid; following write completes normally.
- CLK_DIV=2, TURNAROUND=1 -> read round-trip with 0xFFFFFFFF and 0x00000001 returns correct data; spi_clk period 4 cycles.
